// File: rtl/spi_reg_responder_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_responder_pkg: shared types for the SPI register responder. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package spi_reg_responder_pkg;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
  } spi_cmd_t;

  localparam logic [7:0] SPI_RESP_ID = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } spi_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge: synchronizes async SPI pins into clk28 and flags edges. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic sck,
  input  logic mosi,
  input  logic cs_n,
  output logic sck_s,
  output logic mosi_s,
  output logic cs_n_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   cs_d;

  // CS chain resets to "selected" so a CS already low at reset release gives
  // no falling edge; the host must deselect and reselect to start a frame.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync[0]  <= sck;
      mosi_sync[0] <= mosi;
      cs_sync[0]   <= cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
      sck_d <= sck_sync[SYNC_STAGES-1];
      cs_d  <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign cs_rise  =  cs_n_s & ~cs_d;
  assign cs_fall  = ~cs_n_s &  cs_d;

endmodule

`default_nettype wire

// File: rtl/spi_reg_responder.sv
// ---------------------------------------------------------------------------
// spi_reg_responder: SPI mode-0 responder into a 128-entry register space. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_reg_responder
  import spi_reg_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = SPI_RESP_ID
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [6:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       abort
);

  logic sck_s, mosi_s, cs_n_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic unused_levels;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .cs_n     (spi_cs_n),
    .sck_s    (sck_s),
    .mosi_s   (mosi_s),
    .cs_n_s   (cs_n_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  assign unused_levels = sck_s ^ cs_n_s;

  spi_resp_state_t state;
  logic [2:0]      bit_cnt;
  logic [6:0]      rx_sr;
  logic [7:0]      tx_reg;
  logic [7:0]      hold_reg;
  logic            need_tx;
  logic            addr_inc;
  logic [1:0]      rd_pipe;
  logic [7:0]      rx_byte;
  logic            byte_done;
  spi_cmd_t        cmd;

  assign rx_byte   = {rx_sr, mosi_s};
  assign cmd       = spi_cmd_t'(rx_byte);
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign spi_miso  = tx_reg[7];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      tx_reg      <= 8'hFF;
      hold_reg    <= 8'h00;
      need_tx     <= 1'b0;
      addr_inc    <= 1'b0;
      rd_pipe     <= 2'b00;
      spi_miso_oe <= 1'b0;
      reg_addr    <= 7'd0;
      reg_wr      <= 1'b0;
      reg_wdata   <= 8'h00;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      abort   <= 1'b0;
      rd_pipe <= {rd_pipe[0], reg_rd};

      if (addr_inc) begin
        reg_addr <= reg_addr + 7'd1;
        addr_inc <= 1'b0;
      end

      if (cs_rise) begin
        if (state != ST_IDLE && bit_cnt != 3'd0)
          abort <= 1'b1;
        state       <= ST_IDLE;
        bit_cnt     <= 3'd0;
        tx_reg      <= 8'hFF;
        need_tx     <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else if (cs_fall) begin
        if (state == ST_IDLE) begin
          state       <= ST_CMD;
          bit_cnt     <= 3'd0;
          tx_reg      <= ID_BYTE;
          need_tx     <= 1'b0;
          spi_miso_oe <= 1'b1;
          busy        <= 1'b1;
        end
      end else if (state != ST_IDLE) begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sr   <= rx_byte[6:0];
          // Fetch for the following byte starts as soon as this one begins.
          if (state == ST_RD && bit_cnt == 3'd0)
            reg_rd <= 1'b1;
          if (byte_done) begin
            case (state)
              ST_CMD: begin
                reg_addr <= cmd.addr;
                tx_reg   <= 8'hFF;
                if (cmd.rw) begin
                  state   <= ST_RD;
                  reg_rd  <= 1'b1;
                  need_tx <= 1'b1;
                end else begin
                  state <= ST_WR;
                end
              end
              ST_WR: begin
                reg_wdata <= rx_byte;
                reg_wr    <= 1'b1;
                addr_inc  <= 1'b1;
              end
              ST_RD:   tx_reg <= hold_reg;
              default: ;
            endcase
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          tx_reg <= {tx_reg[6:0], 1'b1};
        end

        // First read of a frame goes straight to MISO; later ones are prefetched.
        if (rd_pipe[1] && state == ST_RD) begin
          if (need_tx) begin
            tx_reg  <= reg_rdata;
            need_tx <= 1'b0;
          end else begin
            hold_reg <= reg_rdata;
          end
          reg_addr <= reg_addr + 7'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_responder: scoreboard bench driving host SPI frames. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_reg_responder;

  localparam int CLK_HALF = 18;
  localparam int CLK_PER  = 36;
  localparam int HP       = 8;

  logic       clk28    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       spi_sck  = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [6:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       abort;

  spi_reg_responder dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wr      (reg_wr),
    .reg_wdata   (reg_wdata),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .abort       (abort)
  );

  always #CLK_HALF clk28 = ~clk28;

  // Register file model: data is valid only in the cycle two after reg_rd.
  logic [1:0] rdp = 2'b00;
  logic [6:0] ra0 = 7'd0;
  logic [6:0] ra1 = 7'd0;
  always @(posedge clk28) begin
    rdp <= {rdp[0], reg_rd};
    ra0 <= reg_addr;
    ra1 <= ra0;
  end
  assign reg_rdata = rdp[1] ? ({1'b0, ra1} + 8'h40) : 8'hEE;

  int vectors     = 0;
  int miscompares = 0;
  int extra_wr    = 0;
  int extra_rd    = 0;
  int abort_cnt   = 0;

  logic [14:0] exp_wr[$];
  logic [6:0]  exp_rd[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  frame_bytes[$];
  logic [14:0] e_wr;
  logic [6:0]  e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk28) begin
    if (reg_wr) begin
      if (exp_wr.size() > 0) begin
        e_wr = exp_wr.pop_front();
        chk("wr_addr_data", {17'd0, reg_addr, reg_wdata}, {17'd0, e_wr});
      end else begin
        extra_wr++;
      end
    end
    if (reg_rd) begin
      if (exp_rd.size() > 0) begin
        e_rd = exp_rd.pop_front();
        chk("rd_addr", {25'd0, reg_addr}, {25'd0, e_rd});
      end else begin
        extra_rd++;
      end
    end
    if (abort) abort_cnt++;
  end

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #(HP*CLK_PER);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      #(HP*CLK_PER);
      spi_sck = 1'b0;
    end
  endtask

  task automatic check_idle(input int aborts_before, input int exp_aborts);
    chk("busy_lo", {31'd0, busy}, 32'd0);
    chk("oe_lo", {31'd0, spi_miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, spi_miso}, 32'd1);
    chk("abort_cnt", abort_cnt - aborts_before, exp_aborts);
    chk("wr_left", exp_wr.size(), 32'd0);
    chk("rd_left", exp_rd.size(), 32'd0);
    chk("wr_extra", extra_wr, 32'd0);
    chk("rd_extra", extra_rd, 32'd0);
  endtask

  task automatic frame(input int tail_bits, input int exp_aborts);
    logic [7:0] rx;
    int a0;
    a0 = abort_cnt;
    @(negedge clk28);
    #($urandom_range(1, CLK_HALF - 1));
    spi_cs_n = 1'b0;
    #(HP*CLK_PER);
    chk("busy_hi", {31'd0, busy}, 32'd1);
    chk("oe_hi", {31'd0, spi_miso_oe}, 32'd1);
    foreach (frame_bytes[i]) begin
      spi_byte(frame_bytes[i], 8, rx);
      if (exp_miso.size() > 0) chk("miso_byte", {24'd0, rx}, {24'd0, exp_miso.pop_front()});
    end
    if (tail_bits > 0) spi_byte(8'hFF, tail_bits, rx);
    #(HP*CLK_PER);
    spi_cs_n = 1'b1;
    #(HP*CLK_PER);
    check_idle(a0, exp_aborts);
    frame_bytes.delete();
    exp_miso.delete();
  endtask

  task automatic check_reset_outputs(input string phase);
    chk({phase, "_miso"},  {31'd0, spi_miso},    32'd1);
    chk({phase, "_oe"},    {31'd0, spi_miso_oe}, 32'd0);
    chk({phase, "_addr"},  {25'd0, reg_addr},    32'd0);
    chk({phase, "_wr"},    {31'd0, reg_wr},      32'd0);
    chk({phase, "_wdata"}, {24'd0, reg_wdata},   32'd0);
    chk({phase, "_rd"},    {31'd0, reg_rd},      32'd0);
    chk({phase, "_busy"},  {31'd0, busy},        32'd0);
    chk({phase, "_abort"}, {31'd0, abort},       32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    int a0;

    repeat (4) @(negedge clk28);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);

    for (int pass = 0; pass < 2; pass++) begin
      exp_miso.push_back(8'hA5);
      exp_wr.push_back({7'h05, 8'h12});
      exp_wr.push_back({7'h06, 8'h34});
      frame_bytes = {8'h05, 8'h12, 8'h34};
      frame(0, 0);

      exp_miso = {8'hA5, 8'h43, 8'h44, 8'h45};
      exp_rd   = {7'h03, 7'h04, 7'h05, 7'h06};
      frame_bytes = {8'h83, 8'h00, 8'h00, 8'h00};
      frame(0, 0);

      exp_miso.push_back(8'hA5);
      exp_wr.push_back({7'h7F, 8'hAA});
      exp_wr.push_back({7'h00, 8'hBB});
      frame_bytes = {8'h7F, 8'hAA, 8'hBB};
      frame(0, 0);

      exp_miso.push_back(8'hA5);
      frame_bytes = {8'h10};
      frame(5, 1);

      exp_miso.push_back(8'hA5);
      exp_wr.push_back({7'h10, 8'h99});
      frame_bytes = {8'h10, 8'h99};
      frame(0, 0);
    end

    // Reset during the second data byte of a read, with CS left low.
    a0 = abort_cnt;
    @(negedge clk28);
    #($urandom_range(1, CLK_HALF - 1));
    exp_rd = {7'h03, 7'h04, 7'h05};
    spi_cs_n = 1'b0;
    #(HP*CLK_PER);
    spi_byte(8'h83, 8, rx);
    chk("rst_miso_cmd", {24'd0, rx}, 32'hA5);
    spi_byte(8'h00, 8, rx);
    chk("rst_miso_d1", {24'd0, rx}, 32'h43);
    spi_byte(8'h00, 4, rx);
    rst_n = 1'b0;
    #(CLK_PER);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    spi_byte(8'h81, 8, rx);
    #(HP*CLK_PER);
    chk("stale_cs_busy", {31'd0, busy}, 32'd0);
    chk("stale_cs_oe", {31'd0, spi_miso_oe}, 32'd0);
    spi_cs_n = 1'b1;
    #(HP*CLK_PER);
    check_idle(a0, 0);

    exp_miso.push_back(8'hA5);
    exp_wr.push_back({7'h22, 8'h5A});
    frame_bytes = {8'h22, 8'h5A};
    frame(0, 0);

    exp_miso = {8'hA5, 8'h7E, 8'h7F};
    exp_rd   = {7'h3E, 7'h3F, 7'h40};
    frame_bytes = {8'hBE, 8'h00, 8'h00};
    frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave (responder) giving an external host MCU access to a 128-entry FPGA register space. Master side is the host; the FPGA answers.
- Sits beside the machine's config/control registers. Shares the protocol family of the SD-card SPI master, seen from the opposite end.
- External SCK/MOSI/CS_n are asynchronous. They are oversampled in the clk28 domain.
- Host frame: one command byte, then N data bytes with address auto-increment.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spi_sck, spi_mosi and spi_cs_n.
- ID_BYTE, 8'hA5, byte shifted out on MISO during the command byte of every frame.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sck  in  1  host SPI clock, asynchronous.
- spi_mosi  in  1  host data in.
- spi_cs_n  in  1  host chip select, active-low.
- spi_miso  out  1  data to host.
- spi_miso_oe  out  1  MISO output enable; high while synced CS is active.
- reg_addr  out  7  current register address.
- reg_wr  out  1  one-clk28 write strobe.
- reg_wdata  out  8  write data; valid while reg_wr is high.
- reg_rd  out  1  one-clk28 pulse; reg_addr is presented for a read.
- reg_rdata  in  8  read data; must be valid 2 clk28 cycles after reg_rd.
- busy  out  1  frame in progress (synced CS low).
- abort  out  1  one-clk28 pulse when CS deasserts mid-byte.

Behaviour:
- Reset values: spi_miso=1, spi_miso_oe=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0, abort=0, state=IDLE, bit_cnt=0.
- Synchronization: inputs pass through SYNC_STAGES flops. Edges come from comparing the last sync stage with one extra flop.
- Edge actions:
  - sck rise: sample MOSI and increment bit_cnt (3-bit, wraps 7->0).
  - sck fall: shift tx_reg left, filling with 1; skipped when bit_cnt==0.
- spi_miso = tx_reg[7].
- Host timing requirement: SCK high and low times >= 8 clk28 cycles (SCK <= 1.75 MHz). CS setup/hold vs SCK >= 8 cycles.
- FSM states: IDLE, CMD, WR, RD.
- IDLE -> CMD on synced CS falling edge:
  - bit_cnt=0, tx_reg=ID_BYTE, spi_miso_oe=1, busy=1.
- CMD, byte complete (8th rise):
  - Byte = {rw, addr[6:0]}; reg_addr<=addr.
  - rw=0: go to WR.
  - rw=1: go to RD and issue reg_rd the next cycle.
- WR, byte complete: reg_wdata<=byte and reg_wr pulses 1 cycle, using the current reg_addr. On the following cycle reg_addr increments.
- RD:
  - reg_rdata is captured into tx_reg exactly 2 cycles after reg_rd.
  - reg_addr then increments and reg_rd pulses again; the next byte is prefetched during the current byte. Prefetched data is held in a holding reg and moved to tx_reg at the byte boundary.
  - MOSI bytes are ignored.
- Address arithmetic: 7-bit, wraps 7F->00, no error.
- Synced CS rising edge, any state:
  - Return to IDLE; spi_miso_oe=0, busy=0, spi_miso=1.
  - If bit_cnt!=0: abort pulses 1 cycle and the partial byte is discarded (no reg_wr).
  - A reg_rd already issued still completes; its data is dropped.
- CS falling and SCK edge in the same cycle: CS wins; the SCK edge is ignored.
- CS low without SCK: state holds indefinitely, no timeout.
- Reset mid-frame: all outputs go to reset values at once. The FSM resynchronizes only on the next CS falling edge; a CS already low is treated as idle until it goes high then low.

Decomposition:
- Shared package: `spi_cmd_t` packed struct {rw, addr[6:0]}, constant `SPI_RESP_ID`, and the FSM state enum `spi_resp_state_t`.
- One natural sub-module: `spi_sync_edge`. It synchronizes sck/mosi/cs_n and outputs sck_rise, sck_fall, cs_fall, cs_rise and the synced levels. It is reusable by other async SPI inputs.

Test Plan:
- Write frame: CS low; send 0x05, 0x12, 0x34; CS high -> reg_wr at addr 05 data 12, then addr 06 data 34. MISO during the command byte = 0xA5. abort never pulses.
- Read frame: model reg_rdata = reg_addr+0x40. Send 0x83 then 3 dummy bytes -> MISO returns A5, 43, 44, 45. Exactly 4 reg_rd pulses (addrs 03, 04, 05, 06; the last is prefetch). No reg_wr.
- Wrap: write frame 0x7F, 0xAA, 0xBB -> reg_wr addr 7F=AA, then addr 00=BB.
- Abort: write frame 0x10, then 5 bits of a data byte, then CS high -> one abort pulse, no reg_wr, busy=0. The next frame 0x10, 0x99 writes addr 10=99 normally.
- Reset mid-frame: assert rst_n low during the 2nd data byte of a read -> outputs at reset values, miso_oe=0. A new frame after CS toggles works correctly.
- Timing margin: run all frames at SCK half-period 8 clk28 cycles with random SCK/clk28 phase -> identical results. At half-period 4, not required to work (documented limit).
